// File: rtl/pipe_stage_buffer_pkg.sv
// Shared stage-boundary definitions: buffer occupancy states and stall counter sizing.
// Used by pipe_stage_buffer at every pipeline boundary (deco/exe, exe/mem, mem/wb).
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int unsigned STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    function automatic logic state_can_accept(input buf_state_t s);
        return s != FULL;
    endfunction

    function automatic logic state_has_head(input buf_state_t s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Two-entry (main + skid) pipeline stage buffer with registered in_ready/out_valid.
// Optional stall cycle counter output when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CU_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CU_W-1:0]   in_cu,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CU_W-1:0]   out_cu,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    buf_state_t state_q;
    buf_state_t state_d;

    logic in_ready_q;
    logic out_valid_q;

    logic [CU_W-1:0]   main_cu_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CU_W-1:0]   skid_cu_q;
    logic [DATA_W-1:0] skid_data_q;

    logic in_xfer;
    logic out_xfer;
    logic load_main_from_in;
    logic load_main_from_skid;
    logic load_skid_from_in;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d             = state_q;
        load_main_from_in   = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid_from_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d           = ONE;
                        load_main_from_in = 1'b1;
                    end
                end
                ONE: begin
                    unique case ({in_xfer, out_xfer})
                        2'b10: begin
                            state_d           = FULL;
                            load_skid_from_in = 1'b1;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: load_main_from_in = 1'b1;
                        default: state_d = ONE;
                    endcase
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d             = ONE;
                        load_main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are separate flops fed from state_d so neither port sees a decode path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_can_accept(state_d);
            out_valid_q <= state_has_head(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (load_main_from_in) begin
            main_cu_q   <= in_cu;
            main_data_q <= in_data;
        end else if (load_main_from_skid) begin
            main_cu_q   <= skid_cu_q;
            main_data_q <= skid_data_q;
        end
        if (load_skid_from_in) begin
            skid_cu_q   <= in_cu;
            skid_data_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    // Control bundle reads as a bubble whenever no head is held.
    assign out_cu    = out_valid_q ? main_cu_q : '0;
    assign out_data  = main_data_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: directed boundary cases plus random traffic.
// Define PIPE_STAGE_STALL_CNT_EN to also exercise the stall counter.
module tb_pipe_stage_buffer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CU_W   = 8;

    typedef struct packed {
        logic [CU_W-1:0]   cu;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CU_W-1:0]   in_cu;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CU_W-1:0]   out_cu;
    logic [DATA_W-1:0] out_data;
    logic              flush;

    entry_t exp_q[$];
    int     occ_at_check = 0;
    int     vectors      = 0;
    int     miscompares  = 0;
    int     stall_m      = 0;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_stage_buffer #(
        .DATA_W(DATA_W),
        .CU_W  (CU_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cu    (in_cu),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cu   (out_cu),
        .out_data (out_data),
        .flush    (flush)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Monitor: reference is a bounded FIFO of capacity two.
    always @(negedge clk) begin : monitor
        logic exp_rdy;
        logic exp_vld;
        if (!rst) begin
            occ_at_check = exp_q.size();
            exp_rdy = (exp_q.size() < 2);
            exp_vld = (exp_q.size() > 0);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
            end
            vectors++;
            if (out_valid !== exp_vld) begin
                miscompares++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_vld, $time);
            end
            if (exp_vld) begin
                vectors++;
                if (out_cu !== exp_q[0].cu) begin
                    miscompares++;
                    $display("FAIL head_cu: got %h expected %h at %0t", out_cu, exp_q[0].cu, $time);
                end
                vectors++;
                if (out_data !== exp_q[0].data) begin
                    miscompares++;
                    $display("FAIL head_data: got %h expected %h at %0t", out_data, exp_q[0].data, $time);
                end
            end else begin
                vectors++;
                if (out_cu !== '0) begin
                    miscompares++;
                    $display("FAIL bubble_cu: got %h expected 00 at %0t", out_cu, $time);
                end
            end
`ifdef PIPE_STAGE_STALL_CNT_EN
            vectors++;
            if (stall_cnt !== 16'(stall_m)) begin
                miscompares++;
                $display("FAIL stall_cnt: got %h expected %h at %0t", stall_cnt, 16'(stall_m), $time);
            end
            if (exp_vld && !out_ready && stall_m < 65535) stall_m++;
`endif
            if (exp_vld && out_ready) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
        end
    end

    task automatic drive(input logic iv, input logic [CU_W-1:0] cu, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl);
        entry_t e;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_cu     = cu;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (iv && !fl && occ_at_check < 2) begin
            e.cu   = cu;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cu !== '0) begin
            miscompares++;
            $display("FAIL %s: got valid=%b ready=%b cu=%h expected valid=0 ready=1 cu=00",
                     tag, out_valid, in_ready, out_cu);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_cu = '0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        #1 rst = 1'b0;

        // Streaming 1..10 with downstream always ready.
        for (int i = 1; i <= 10; i++) drive(1'b1, CU_W'(i), DATA_W'(i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: A,B accepted, C held off until A leaves.
        drive(1'b1, 8'hA1, DATA_W'(32'hA), 1'b0, 1'b0);
        drive(1'b1, 8'hB2, DATA_W'(32'hB), 1'b0, 1'b0);
        drive(1'b1, 8'hC3, DATA_W'(32'hC), 1'b0, 1'b0);
        drive(1'b1, 8'hC3, DATA_W'(32'hC), 1'b1, 1'b0);
        drive(1'b1, 8'hC3, DATA_W'(32'hC), 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while FULL with a new input presented.
        drive(1'b1, 8'h11, rand_data(), 1'b0, 1'b0);
        drive(1'b1, 8'h22, rand_data(), 1'b0, 1'b0);
        drive(1'b1, 8'h33, rand_data(), 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Asynchronous reset while holding one entry.
        drive(1'b1, 8'h44, rand_data(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        stall_m = 0;
        #1;
        check_reset_outputs("async_reset");
        #1 rst = 1'b0;
        drive(1'b1, 8'h55, rand_data(), 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), CU_W'($urandom_range(1, 255)), rand_data(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
        end

`ifdef PIPE_STAGE_STALL_CNT_EN
        drive(1'b1, 8'h66, rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stall_sat: got %h expected ffff", stall_cnt);
        end
`endif

        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
